regfile_seq: RTL
================

# regfile_seq

Control sequencer for the 8×16-bit register file. It accepts one register-transfer command at a time over a req/ack handshake. It drives the register file's L/R read ports, O write port and the ALU result-latch strobe through fixed per-opcode phases. It sits between the instruction decoder and the regfile/ALU datapath, carries no data itself, and keeps a retired-command counter.

## Interface
Parameters:
- CNT_W, 8, width of the retired-command counter

Ports:
- ck  in  1  clock; all state changes on the rising edge
- res  in  1  reset; synchronous, active-low (res=0 at a rising edge resets)
- req  in  1  command valid
- op  in  2  opcode: 00 RR, 01 MOV, 10 OUT, 11 LOAD
- rd  in  3  destination register
- rs1  in  3  first source, driven on Lbus
- rs2  in  3  second source, driven on Rbus
- ack  out  1  ready to accept; a command transfers on an edge with req&&ack
- LSEL  out  3  L read select
- LOUT  out  1  L read enable
- RSEL  out  3  R read select
- ROUT  out  1  R read enable
- OSEL  out  3  write select
- OIN  out  1  write enable
- LATCH  out  1  ALU result register capture strobe
- OSRC  out  1  Obus source: 0 = ALU latch, 1 = external bus
- done  out  1  one-cycle pulse on command completion
- icount  out  CNT_W  retired-command count

## Operation
- States: IDLE, READ, WRITE, DONE. IDLE is the only state with ack=1.
- In IDLE, req=1 captures op, rd, rs1 and rs2 into internal registers. The next state is:
  - READ for RR, MOV and OUT.
  - WRITE for LOAD.
- In IDLE, req=0 keeps the block in IDLE.
- READ:
  - LOUT=1 and LSEL=rs1.
  - For RR only: ROUT=1 and RSEL=rs2.
  - LATCH=1.
  - Next state is WRITE for RR and MOV, DONE for OUT.
- WRITE:
  - OIN=1 and OSEL=rd.
  - OSRC=1 for LOAD, 0 otherwise.
  - Next state is DONE.
- DONE:
  - done=1.
  - icount increments by 1 and wraps at 2^CNT_W−1 → 0.
  - Next state is IDLE.
- When a port enable is low, its select output is 3'o0. LATCH, OIN, LOUT and ROUT are never high outside their phase.
- All outputs are decoded from the registered state and the captured command. There is no combinational path from req/op/rd/rs to any datapath control.
- Input changes on op/rd/rs while not in IDLE are ignored.
- rd may equal rs1 or rs2. The read happens in READ and the write happens in a later cycle, so there is no hazard.

## Timing
- Reset (res=0 at an edge) gives: state IDLE, ack=1, icount=0, and all of done, LATCH, LOUT, ROUT, OIN, OSRC=0 with selects 3'o0.
  - Reset wins over every other event, including mid-command.
  - A command aborted by reset is discarded: no write, no done, no count.
- Edge 0 is the accepting edge. Cycles after it:
  - RR and MOV: READ in cycle 1, WRITE in cycle 2, DONE in cycle 3, ack=1 again in cycle 4. Throughput is 1 command per 4 cycles.
  - OUT: READ in cycle 1, DONE in cycle 2, ack in cycle 3.
  - LOAD: WRITE in cycle 1, DONE in cycle 2, ack in cycle 3.
- req held high continuously gives back-to-back commands. A new command is accepted in the first IDLE cycle after DONE.
- The regfile samples OSEL/OIN/Obus at the edge ending the WRITE cycle. The ALU latch captures at the edge ending READ.

## Structure
- Shared package cpu_pkg holds:
  - Opcode constants OP_RR=2'b00, OP_MOV=2'b01, OP_OUT=2'b10, OP_LOAD=2'b11.
  - State encodings S_IDLE, S_READ, S_WRITE, S_DONE.
- Single module. No sub-module: the opcode-to-phase decode is a few lines of combinational logic inside.

## Test plan
- Reset: res=0 for 2 cycles with req=1, op=RR → ack=1, all enables 0, selects 0, icount=0, no command accepted.
- RR: rd=3, rs1=1, rs2=2.
  - Cycle 1: LOUT=1 LSEL=1, ROUT=1 RSEL=2, LATCH=1.
  - Cycle 2: OIN=1 OSEL=3 OSRC=0.
  - Cycle 3: done=1, icount=1.
  - Cycle 4: ack=1.
- OUT rs1=5 then LOAD rd=7 back-to-back with req held high:
  - OUT: READ with LSEL=5 and ROUT=0, then DONE with no WRITE.
  - LOAD: accepted in the next IDLE, WRITE with OSEL=7 OSRC=1, done, icount=2.
- Reset mid-command: res=0 during the WRITE of MOV rd=4 → OIN=0 after the edge, no done, icount unchanged, IDLE.
- Wrap: with CNT_W=2, run 5 commands → icount sequence 1,2,3,0,1.
- Input churn: change op/rd/rs every cycle while busy → outputs reflect only the captured command.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the CPU control slice: the 2-bit opcode encodings
//   seen by the register-transfer sequencer and the sequencer's state
//   encodings. No ports; import with `import cpu_pkg::*;`.
package cpu_pkg;

  // Register-transfer opcodes
  localparam logic [1:0] OP_RR   = 2'b00;  // L op R -> ALU latch -> rd
  localparam logic [1:0] OP_MOV  = 2'b01;  // rs1 -> ALU latch -> rd
  localparam logic [1:0] OP_OUT  = 2'b10;  // rs1 -> ALU latch, no writeback
  localparam logic [1:0] OP_LOAD = 2'b11;  // external bus -> rd

  // Sequencer phases
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_seq.sv
// regfile_seq
//   Control sequencer for the 8x16 register file. Accepts one register-
//   transfer command at a time and walks it through fixed phases that drive
//   the L/R read ports, the O write port and the ALU result-latch strobe.
//   Carries no data; counts retired commands.
//
// Ports
//   ck         clock, rising edge
//   res        synchronous active-low reset
//   req        command valid
//   op[1:0]    opcode (RR, MOV, OUT, LOAD)
//   rd[2:0]    destination register
//   rs1[2:0]   source driven onto Lbus
//   rs2[2:0]   source driven onto Rbus (RR only)
//   ack        ready to accept a command (IDLE only)
//   LSEL/LOUT  L read port select / enable
//   RSEL/ROUT  R read port select / enable
//   OSEL/OIN   write port select / enable
//   LATCH      ALU result register capture strobe
//   OSRC       Obus source: 0 = ALU latch, 1 = external bus
//   done       one-cycle pulse when a command completes
//   icount     retired-command counter, wraps
//   dbg_state  current sequencer state (cpu_pkg::state_t encoding)
//
// Handshake: req is the producer's valid, ack the sequencer's ready. A command
// (op/rd/rs1/rs2) transfers on any rising edge where req && ack; ack does not
// depend on req. Once transferred, the command is held internally and
// op/rd/rs1/rs2/req are ignored until the sequencer returns to IDLE.
module regfile_seq
  import cpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             res,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [2:0]       rd,
  input  logic [2:0]       rs1,
  input  logic [2:0]       rs2,
  output logic             ack,
  output logic [2:0]       LSEL,
  output logic             LOUT,
  output logic [2:0]       RSEL,
  output logic             ROUT,
  output logic [2:0]       OSEL,
  output logic             OIN,
  output logic             LATCH,
  output logic             OSRC,
  output logic             done,
  output logic [CNT_W-1:0] icount,
  output logic [1:0]       dbg_state
);

  state_t     state, state_nxt;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic       accept;

  assign accept = (state == S_IDLE) && req;

  // State register
  always_ff @(posedge ck) begin
    if (!res) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captured command; only loaded on a transfer so busy-time input churn
  // never reaches the outputs.
  always_ff @(posedge ck) begin
    if (!res) begin
      cmd_op  <= OP_RR;
      cmd_rd  <= 3'o0;
      cmd_rs1 <= 3'o0;
      cmd_rs2 <= 3'o0;
    end else if (accept) begin
      cmd_op  <= op;
      cmd_rd  <= rd;
      cmd_rs1 <= rs1;
      cmd_rs2 <= rs2;
    end
  end

  // The count is bumped on the edge entering DONE so that it already shows
  // the new value while done is high. A reset before that edge discards the
  // command without counting it.
  always_ff @(posedge ck) begin
    if (!res) begin
      icount <= '0;
    end else if (state != S_DONE && state_nxt == S_DONE) begin
      icount <= icount + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = (op == OP_LOAD) ? S_WRITE : S_READ;
      S_READ:  state_nxt = (cmd_op == OP_OUT) ? S_DONE : S_WRITE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: from registered state and captured command only.
  // Selects are forced to 0 whenever their enable is low.
  always_comb begin
    ack   = 1'b0;
    LSEL  = 3'o0;
    LOUT  = 1'b0;
    RSEL  = 3'o0;
    ROUT  = 1'b0;
    OSEL  = 3'o0;
    OIN   = 1'b0;
    LATCH = 1'b0;
    OSRC  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE: ack = 1'b1;
      S_READ: begin
        LOUT  = 1'b1;
        LSEL  = cmd_rs1;
        LATCH = 1'b1;
        if (cmd_op == OP_RR) begin
          ROUT = 1'b1;
          RSEL = cmd_rs2;
        end
      end
      S_WRITE: begin
        OIN  = 1'b1;
        OSEL = cmd_rd;
        OSRC = (cmd_op == OP_LOAD);
      end
      S_DONE:  done = 1'b1;
      default: ack = 1'b0;
    endcase
  end

  assign dbg_state = state;

endmodule
